// File: rtl/mem_port_arbiter_2to1_pkg.sv
// rtl/mem_port_arbiter_2to1_pkg.sv - shared state encoding, select codes and widths for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  localparam logic SEL_A      = 1'b0;
  localparam logic SEL_B      = 1'b1;
  localparam int   WAIT_CNT_W = 8;

  // Round-robin pick: a lone requester wins outright, contention goes to whoever did not win last.
  function automatic logic rr_pick(input logic req_a, input logic req_b, input logic last_win);
    logic pick;
    if (req_a && req_b) begin
      pick = (last_win == SEL_A) ? SEL_B : SEL_A;
    end else if (req_b) begin
      pick = SEL_B;
    end else begin
      pick = SEL_A;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_2to1_if.sv
// rtl/mem_port_arbiter_2to1_if.sv - requester, memory and completion signals of the shared memory port
interface mem_port_arbiter_2to1_if;
  import mem_arb_pkg::*;

  logic        req_a;
  logic [31:0] addr_a;
  logic        req_b;
  logic [31:0] addr_b;
  logic        mem_ack;

  logic        sel;
  logic        gnt_a;
  logic        gnt_b;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        done_a;
  logic        done_b;
  logic        err;

  // master: the requesters and memory around the arbiter; slave: the arbiter itself
  modport master (
    output req_a, addr_a, req_b, addr_b, mem_ack,
    input  sel, gnt_a, gnt_b, mem_addr, mem_req, done_a, done_b, err
  );

  modport slave (
    input  req_a, addr_a, req_b, addr_b, mem_ack,
    output sel, gnt_a, gnt_b, mem_addr, mem_req, done_a, done_b, err
  );

endinterface

// File: rtl/mem_port_arbiter_2to1_mux.sv
// rtl/mem_port_arbiter_2to1_mux.sv - 2:1 32-bit word select feeding the registered memory address
module Mux32Bit2To1
  import mem_arb_pkg::*;
(
  input  logic        sel,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic [31:0] y
);

  assign y = (sel == SEL_B) ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter_2to1.sv
// rtl/mem_port_arbiter_2to1.sv - round-robin 2:1 arbiter and req/ack sequencer with hung-access timeout
module mem_port_arbiter_2to1
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_port_arbiter_2to1_if.slave  bus
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  arb_state_t             state;
  arb_state_t             state_nx;
  logic                   sel_q;
  logic [31:0]            mem_addr_q;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic [WAIT_CNT_W-1:0]  wait_cnt_nx;
  logic                   last_win;
  logic                   err_q;
  logic                   err_nx;
  logic                   win_go;
  logic                   win_sel;
  logic [31:0]            mux_addr;

  Mux32Bit2To1 u_addr_mux (
    .sel (win_sel),
    .in0 (bus.addr_a),
    .in1 (bus.addr_b),
    .y   (mux_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel_q      <= SEL_A;
      mem_addr_q <= '0;
      wait_cnt   <= '0;
      last_win   <= SEL_B;
      err_q      <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      err_q    <= err_nx;
      // A timed-out turn still counts as a win so the other side gets priority next.
      if (win_go) begin
        sel_q      <= win_sel;
        mem_addr_q <= mux_addr;
        last_win   <= win_sel;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    err_nx      = err_q;
    win_go      = 1'b0;
    win_sel     = SEL_A;
    unique case (state)
      ST_IDLE: begin
        win_sel = rr_pick(bus.req_a, bus.req_b, last_win);
        if (bus.req_a || bus.req_b) begin
          win_go      = 1'b1;
          wait_cnt_nx = '0;
          state_nx    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ack) begin
          err_nx   = 1'b0;
          state_nx = ST_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          err_nx   = 1'b1;
          state_nx = ST_DONE;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Every output decodes flops only, so nothing combinational reaches them from the inputs.
  assign bus.sel      = sel_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.gnt_a    = (state != ST_IDLE) && (sel_q == SEL_A);
  assign bus.gnt_b    = (state != ST_IDLE) && (sel_q == SEL_B);
  assign bus.mem_req  = (state == ST_BUSY);
  assign bus.done_a   = (state == ST_DONE) && (sel_q == SEL_A);
  assign bus.done_b   = (state == ST_DONE) && (sel_q == SEL_B);
  assign bus.err      = (state == ST_DONE) && err_q;

  a_single_done: assert property (@(posedge clk) disable iff (reset)
    !(bus.done_a && bus.done_b));

  a_wait_bound: assert property (@(posedge clk) disable iff (reset)
    (state != ST_BUSY) || (wait_cnt <= WAIT_LAST));

endmodule

// File: tb/tb_mem_port_arbiter_2to1.sv
// tb/tb_mem_port_arbiter_2to1.sv - scoreboard bench for the 2:1 memory port arbiter
module tb_mem_port_arbiter_2to1;
  import mem_arb_pkg::*;

  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_2to1_if bus_if ();

  mem_port_arbiter_2to1 #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  typedef struct {
    logic        got_done;
    logic        done_a;
    logic        done_b;
    logic        err;
    logic        gnt_a;
    logic        gnt_b;
    logic [31:0] addr;
    logic        first_sel;
    logic [31:0] first_addr;
    int          req_cycles;
    int          grant_lat;
    int          done_lat;
    int          err_stray;
  } obs_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   ack_after = 1;

  // Memory model: acks on the ack_after-th BUSY cycle (never if negative); returns at the Done cycle.
  task automatic wait_done(input int budget, output obs_t o);
    int busy_seen;
    busy_seen = 0;
    o = '{default: 0};
    o.grant_lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus_if.mem_req) begin
        busy_seen++;
        o.req_cycles++;
        if (o.grant_lat < 0) begin
          o.grant_lat  = c;
          o.first_sel  = bus_if.sel;
          o.first_addr = bus_if.mem_addr;
        end
      end
      if (bus_if.err && !(bus_if.done_a || bus_if.done_b)) o.err_stray++;
      if (bus_if.done_a || bus_if.done_b) begin
        o.got_done = 1'b1;
        o.done_a   = bus_if.done_a;
        o.done_b   = bus_if.done_b;
        o.err      = bus_if.err;
        o.gnt_a    = bus_if.gnt_a;
        o.gnt_b    = bus_if.gnt_b;
        o.addr     = bus_if.mem_addr;
        o.done_lat = c;
        break;
      end
      bus_if.mem_ack = bus_if.mem_req && (ack_after >= 0) && (busy_seen == ack_after);
    end
    bus_if.mem_ack = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e, output logic have);
    have = (exp_q.size() != 0);
    if (have) e = exp_q.pop_front();
    else      e = '{sel: 1'b0, addr: 32'h0, err: 1'b0};
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus_if.req_a   = 1'b0;
    bus_if.req_b   = 1'b0;
    bus_if.addr_a  = 32'h0;
    bus_if.addr_b  = 32'h0;
    bus_if.mem_ack = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus_if.req_a   = 1'b1;
    bus_if.req_b   = 1'b1;
    bus_if.addr_a  = 32'hDEAD_0000;
    bus_if.addr_b  = 32'hBEEF_0000;
    bus_if.mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_if.sel, bus_if.gnt_a, bus_if.gnt_b, bus_if.mem_req, bus_if.done_a, bus_if.done_b, bus_if.err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got sel/gnt_a/gnt_b/mem_req/done_a/done_b/err=%b, want 0000000",
               {bus_if.sel, bus_if.gnt_a, bus_if.gnt_b, bus_if.mem_req, bus_if.done_a, bus_if.done_b, bus_if.err});
    end
    n_checks++;
    if (bus_if.mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h, want 00000000", bus_if.mem_addr);
    end
    bus_if.req_a   = 1'b0;
    bus_if.req_b   = 1'b0;
    bus_if.mem_ack = 1'b0;
    reset          = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_if.gnt_a, bus_if.gnt_b, bus_if.mem_req} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt_a/gnt_b/mem_req=%b, want 000", {bus_if.gnt_a, bus_if.gnt_b, bus_if.mem_req});
    end
  endtask

  task automatic test_single_a();
    obs_t o; exp_t e; logic have;
    do_reset();
    ack_after     = 2;
    bus_if.req_a  = 1'b1;
    bus_if.addr_a = 32'h0040_0000;
    exp_q.push_back('{sel: SEL_A, addr: 32'h0040_0000, err: 1'b0});
    wait_done(20, o);
    bus_if.req_a = 1'b0;
    n_checks++;
    if (o.grant_lat !== 1 || o.first_sel !== SEL_A || o.first_addr !== 32'h0040_0000) begin
      n_fail++;
      $display("FAIL single_grant: got lat=%0d sel=%0b addr=%h, want lat=1 sel=0 addr=00400000", o.grant_lat, o.first_sel, o.first_addr);
    end
    n_checks++;
    if (o.req_cycles !== 2 || o.done_lat !== 3) begin
      n_fail++;
      $display("FAIL single_timing: got mem_req cycles=%0d done at %0d, want 2 and 3", o.req_cycles, o.done_lat);
    end
    pop_exp(e, have);
    n_checks++;
    if (!have || !o.got_done || {o.done_a, o.done_b, o.err, o.gnt_a, o.addr} !== {e.sel == SEL_A, e.sel == SEL_B, e.err, 1'b1, e.addr}) begin
      n_fail++;
      $display("FAIL single_done: got done=%0b a=%0b b=%0b err=%0b gnt_a=%0b addr=%h, want a=1 b=0 err=%0b gnt_a=1 addr=%h",
               o.got_done, o.done_a, o.done_b, o.err, o.gnt_a, o.addr, e.err, e.addr);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_if.done_a, bus_if.gnt_a, bus_if.mem_req, bus_if.err} !== 4'b0) begin
      n_fail++;
      $display("FAIL single_pulse_end: got done_a/gnt_a/mem_req/err=%b, want 0000",
               {bus_if.done_a, bus_if.gnt_a, bus_if.mem_req, bus_if.err});
    end
  endtask

  task automatic test_round_robin();
    obs_t o; exp_t e; logic have;
    do_reset();
    ack_after     = 1;
    bus_if.addr_a = 32'h0000_0100;
    bus_if.addr_b = 32'h0000_0200;
    bus_if.req_a  = 1'b1;
    bus_if.req_b  = 1'b1;
    exp_q.push_back('{sel: SEL_A, addr: 32'h100, err: 1'b0});
    exp_q.push_back('{sel: SEL_B, addr: 32'h200, err: 1'b0});
    for (int t = 0; t < 4; t++) begin
      wait_done(20, o);
      pop_exp(e, have);
      n_checks++;
      if (!have || !o.got_done || {o.first_sel, o.first_addr, o.done_a, o.done_b, o.addr} !==
          {e.sel, e.addr, e.sel == SEL_A, e.sel == SEL_B, e.addr}) begin
        n_fail++;
        $display("FAIL rr_turn%0d: got sel=%0b addr=%h done_a=%0b done_b=%0b, want sel=%0b addr=%h",
                 t, o.first_sel, o.first_addr, o.done_a, o.done_b, e.sel, e.addr);
      end
      n_checks++;
      if (o.grant_lat !== ((t == 0) ? 1 : 2) || o.done_lat !== o.grant_lat + 1) begin
        n_fail++;
        $display("FAIL rr_turnaround%0d: got grant at %0d done at %0d, want grant at %0d done one later",
                 t, o.grant_lat, o.done_lat, (t == 0) ? 1 : 2);
      end
      if (t < 2) exp_q.push_back(e);
      else if (o.done_a) bus_if.req_a = 1'b0;
      else               bus_if.req_b = 1'b0;
    end
    bus_if.req_a = 1'b0;
    bus_if.req_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e; logic have;
    do_reset();
    ack_after     = -1;
    bus_if.req_b  = 1'b1;
    bus_if.addr_b = 32'hBEEF_0000;
    exp_q.push_back('{sel: SEL_B, addr: 32'hBEEF_0000, err: 1'b1});
    wait_done(40, o);
    bus_if.req_b = 1'b0;
    n_checks++;
    if (o.req_cycles !== TIMEOUT || o.grant_lat !== 1 || o.done_lat !== TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL timeout_len: got mem_req cycles=%0d grant=%0d done=%0d, want %0d, 1, %0d",
               o.req_cycles, o.grant_lat, o.done_lat, TIMEOUT, TIMEOUT + 1);
    end
    pop_exp(e, have);
    n_checks++;
    if (!have || !o.got_done || {o.done_a, o.done_b, o.err, o.gnt_b, o.addr} !== {e.sel == SEL_A, e.sel == SEL_B, e.err, 1'b1, e.addr}) begin
      n_fail++;
      $display("FAIL timeout_done: got done=%0b a=%0b b=%0b err=%0b gnt_b=%0b addr=%h, want a=0 b=1 err=1 gnt_b=1 addr=%h",
               o.got_done, o.done_a, o.done_b, o.err, o.gnt_b, o.addr, e.addr);
    end
    n_checks++;
    if (o.err_stray !== 0) begin
      n_fail++;
      $display("FAIL timeout_err_early: got %0d cycles of err without done, want 0", o.err_stray);
    end
    @(negedge clk);
    n_checks++;
    if ({bus_if.mem_req, bus_if.gnt_b, bus_if.done_b, bus_if.err} !== 4'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: got mem_req/gnt_b/done_b/err=%b, want 0000",
               {bus_if.mem_req, bus_if.gnt_b, bus_if.done_b, bus_if.err});
    end
  endtask

  task automatic test_stray_ack();
    obs_t o; exp_t e; logic have;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus_if.mem_ack = (i != 1);
      @(negedge clk);
      n_checks++;
      if ({bus_if.mem_req, bus_if.gnt_a, bus_if.gnt_b, bus_if.done_a, bus_if.done_b, bus_if.err} !== 6'b0) begin
        n_fail++;
        $display("FAIL stray_idle%0d: got mem_req/gnt_a/gnt_b/done_a/done_b/err=%b, want 000000", i,
                 {bus_if.mem_req, bus_if.gnt_a, bus_if.gnt_b, bus_if.done_a, bus_if.done_b, bus_if.err});
      end
    end
    bus_if.mem_ack = 1'b0;
    ack_after      = 1;
    bus_if.req_a   = 1'b1;
    bus_if.addr_a  = 32'h0000_0A00;
    exp_q.push_back('{sel: SEL_A, addr: 32'h0000_0A00, err: 1'b0});
    wait_done(20, o);
    bus_if.req_a   = 1'b0;
    bus_if.mem_ack = 1'b1;
    pop_exp(e, have);
    n_checks++;
    if (!have || !o.got_done || {o.done_a, o.done_b, o.err, o.addr} !== {e.sel == SEL_A, e.sel == SEL_B, e.err, e.addr}) begin
      n_fail++;
      $display("FAIL stray_access: got done=%0b a=%0b b=%0b err=%0b addr=%h, want a=1 b=0 err=0 addr=%h",
               o.got_done, o.done_a, o.done_b, o.err, o.addr, e.addr);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      n_checks++;
      if ({bus_if.mem_req, bus_if.gnt_a, bus_if.done_a, bus_if.done_b, bus_if.err} !== 5'b0) begin
        n_fail++;
        $display("FAIL stray_done%0d: got mem_req/gnt_a/done_a/done_b/err=%b, want 00000", i,
                 {bus_if.mem_req, bus_if.gnt_a, bus_if.done_a, bus_if.done_b, bus_if.err});
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    obs_t o; exp_t e; logic have; int seen;
    do_reset();
    ack_after     = -1;
    bus_if.req_a  = 1'b1;
    bus_if.addr_a = 32'h0000_0300;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus_if.mem_req, bus_if.gnt_a} !== 2'b11) begin
      n_fail++;
      $display("FAIL midbusy_pre: got mem_req/gnt_a=%b, want 11", {bus_if.mem_req, bus_if.gnt_a});
    end
    reset        = 1'b1;
    bus_if.req_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_if.sel, bus_if.gnt_a, bus_if.gnt_b, bus_if.mem_req, bus_if.done_a, bus_if.done_b, bus_if.err, bus_if.mem_addr} !== 39'b0) begin
      n_fail++;
      $display("FAIL midbusy_reset: got ctl=%b addr=%h, want all zero",
               {bus_if.sel, bus_if.gnt_a, bus_if.gnt_b, bus_if.mem_req, bus_if.done_a, bus_if.done_b, bus_if.err}, bus_if.mem_addr);
    end
    reset = 1'b0;
    seen  = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.done_a || bus_if.done_b) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midbusy_nodone: got %0d done pulses, want 0", seen);
    end
    ack_after     = 1;
    bus_if.addr_a = 32'h0000_0111;
    bus_if.addr_b = 32'h0000_0222;
    bus_if.req_a  = 1'b1;
    bus_if.req_b  = 1'b1;
    exp_q.push_back('{sel: SEL_A, addr: 32'h0000_0111, err: 1'b0});
    wait_done(20, o);
    bus_if.req_a = 1'b0;
    bus_if.req_b = 1'b0;
    pop_exp(e, have);
    n_checks++;
    if (!have || !o.got_done || {o.first_sel, o.done_a, o.done_b, o.addr} !== {e.sel, e.sel == SEL_A, e.sel == SEL_B, e.addr}) begin
      n_fail++;
      $display("FAIL midbusy_next: got sel=%0b done_a=%0b done_b=%0b addr=%h, want sel=0 done_a=1 addr=%h",
               o.first_sel, o.done_a, o.done_b, o.addr, e.addr);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e; logic have;
    do_reset();
    ack_after     = 1;
    bus_if.req_a  = 1'b1;
    bus_if.addr_a = 32'h0000_1000;
    exp_q.push_back('{sel: SEL_A, addr: 32'h0000_1000, err: 1'b0});
    @(negedge clk);
    bus_if.req_b  = 1'b1;
    bus_if.addr_b = 32'h0000_2000;
    exp_q.push_back('{sel: SEL_B, addr: 32'h0000_2000, err: 1'b0});
    for (int t = 0; t < 3; t++) begin
      wait_done(20, o);
      pop_exp(e, have);
      n_checks++;
      if (!have || !o.got_done || {o.done_a, o.done_b, o.err, o.addr} !== {e.sel == SEL_A, e.sel == SEL_B, e.err, e.addr}) begin
        n_fail++;
        $display("FAIL b2b_turn%0d: got done=%0b a=%0b b=%0b err=%0b addr=%h, want a=%0b b=%0b addr=%h",
                 t, o.got_done, o.done_a, o.done_b, o.err, o.addr, e.sel == SEL_A, e.sel == SEL_B, e.addr);
      end
      if (t == 0) begin
        bus_if.addr_a = 32'h0000_1004;
        exp_q.push_back('{sel: SEL_A, addr: 32'h0000_1004, err: 1'b0});
      end else if (t == 1) begin
        bus_if.req_b = 1'b0;
      end else begin
        bus_if.req_a = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || {bus_if.mem_req, bus_if.gnt_a, bus_if.gnt_b} !== 3'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d pending, mem_req/gnt_a/gnt_b=%b, want 0 and 000",
               exp_q.size(), {bus_if.mem_req, bus_if.gnt_a, bus_if.gnt_b});
    end
  endtask

  initial begin
    bus_if.req_a   = 1'b0;
    bus_if.req_b   = 1'b0;
    bus_if.addr_a  = 32'h0;
    bus_if.addr_b  = 32'h0;
    bus_if.mem_ack = 1'b0;
    test_reset();
    test_single_a();
    test_round_robin();
    test_timeout();
    test_stray_ack();
    test_reset_mid_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
